// File: rtl/traffic_pattern_gen.sv
// traffic_pattern_gen: scrolling car map for the 16x16 matrix. Lanes 1..14 shift at per-lane rates, and an LFSR spawns new cars.
// Latency: tick is combinational from the prescaler, and lanes/LFSR update on the edge that closes a tick cycle; enable=0 freezes everything.
// Optional SAFE_MEDIAN_EN: row 8 becomes a permanently clear median.
module traffic_pattern_gen #(
    parameter logic [23:0] TICK_DIV = 24'd2_500_000,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              win,
    output logic [15:0][15:0] RedPixelsPattern,
    output logic [1:0]        level,
    output logic              tick
);
    localparam logic [15:0] LFSR_INIT = (SEED == 16'd0) ? 16'hACE1 : SEED;
`ifdef SAFE_MEDIAN_EN
    localparam bit MEDIAN = 1'b1;
`else
    localparam bit MEDIAN = 1'b0;
`endif

    logic [23:0] presc;
    logic [23:0] shifted;
    logic [23:0] period;
    logic [15:0] lfsr;
    logic        win_d;
    logic        level_up;

    always_comb begin
        shifted = TICK_DIV >> level;
        period  = (shifted == 24'd0) ? 24'd1 : shifted;
    end

    assign tick     = !reset && enable && (presc == period - 24'd1);
    assign level_up = enable && win && !win_d && (level != 2'd3);

    // A level change restarts the prescaler; any tick in that same cycle still fires with the old period.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
            level <= '0;
            win_d <= 1'b0;
            lfsr  <= LFSR_INIT;
        end else begin
            win_d <= win;
            if (level_up) begin
                level <= level + 2'd1;
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
            end else if (enable) begin
                presc <= presc + 24'd1;
            end
            if (tick)
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    for (genvar r = 0; r < 16; r++) begin : g_row
        if (r == 0 || r == 15 || (MEDIAN && r == 8)) begin : g_clear
            assign RedPixelsPattern[r] = 16'd0;
        end else begin : g_lane
            localparam logic [1:0] SPEED = 2'(r % 4);
            logic [1:0]  cnt;
            logic [1:0]  run_len;
            logic        car;
            logic        ins;
            logic [15:0] row;

            // Cap cars at 3 and keep gaps at least 2 wide so the frog always has a way through.
            always_comb begin
                ins = lfsr[r];
                if (car && run_len == 2'd3)
                    ins = 1'b0;
                else if (!car && run_len < 2'd2)
                    ins = 1'b0;
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt     <= 2'd0;
                    run_len <= 2'd2;
                    car     <= 1'b0;
                    row     <= 16'd0;
                end else if (tick) begin
                    if (cnt == SPEED) begin
                        cnt <= 2'd0;
                        row <= (r % 2 == 0) ? {row[14:0], ins} : {ins, row[15:1]};
                        if (ins == car) begin
                            if (run_len != 2'd3)
                                run_len <= run_len + 2'd1;
                        end else begin
                            car     <= ins;
                            run_len <= 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
            end

            assign RedPixelsPattern[r] = row;
        end
    end
endmodule

// File: tb/tb_traffic_pattern_gen.sv
// Bench for traffic_pattern_gen with TICK_DIV=4: reset, tick timing, lane rate/direction, level table, freeze, replay after reset, lane rules.
`timescale 1ns/1ps
module tb_traffic_pattern_gen;
    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic              win = 1'b0;
    logic [15:0][15:0] RedPixelsPattern;
    logic [1:0]        level;
    logic              tick;

    int errors = 0;
    int checks = 0;

    traffic_pattern_gen #(.TICK_DIV(24'd4), .SEED(16'hACE1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .win(win),
        .RedPixelsPattern(RedPixelsPattern), .level(level), .tick(tick)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model of the spec behaviour
    logic [15:0] m_pat [16];
    logic [1:0]  m_cnt [16];
    logic [1:0]  m_run [16];
    logic        m_car [16];
    logic [15:0] m_lfsr;
    int          m_presc;
    logic [1:0]  m_level;
    logic        m_wind;

    function automatic bit is_lane(int r);
        bit ok;
        ok = (r != 0) && (r != 15);
`ifdef SAFE_MEDIAN_EN
        if (r == 8) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic int period_of(logic [1:0] l);
        int p;
        p = 4 >> l;
        return (p < 1) ? 1 : p;
    endfunction

    function automatic bit m_tick(bit rst, bit en);
        return !rst && en && (m_presc == period_of(m_level) - 1);
    endfunction

    function automatic logic [15:0][15:0] model_pat();
        logic [15:0][15:0] p;
        for (int r = 0; r < 16; r++) p[r] = m_pat[r];
        return p;
    endfunction

    task automatic m_edge(input bit rst, input bit en, input bit w);
        bit tk;
        bit ins;
        tk = m_tick(rst, en);
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                m_pat[r] = '0; m_cnt[r] = '0; m_car[r] = 1'b0; m_run[r] = 2'd2;
            end
            m_lfsr = 16'hACE1; m_presc = 0; m_level = '0; m_wind = 1'b0;
        end else begin
            if (tk) begin
                for (int r = 1; r < 15; r++) begin
                    if (is_lane(r)) begin
                        if (int'(m_cnt[r]) == r % 4) begin
                            if (m_car[r] && m_run[r] == 2'd3) ins = 1'b0;
                            else if (!m_car[r] && m_run[r] < 2'd2) ins = 1'b0;
                            else ins = m_lfsr[r];
                            if (r % 2 == 0) m_pat[r] = {m_pat[r][14:0], ins};
                            else m_pat[r] = {ins, m_pat[r][15:1]};
                            if (ins == m_car[r]) begin
                                if (m_run[r] != 2'd3) m_run[r] = m_run[r] + 2'd1;
                            end else begin
                                m_car[r] = ins; m_run[r] = 2'd1;
                            end
                            m_cnt[r] = 2'd0;
                        end else begin
                            m_cnt[r] = m_cnt[r] + 2'd1;
                        end
                    end
                end
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            end
            if (en && w && !m_wind && m_level != 2'd3) begin
                m_level = m_level + 2'd1; m_presc = 0;
            end else if (tk) begin
                m_presc = 0;
            end else if (en) begin
                m_presc++;
            end
            m_wind = w;
        end
    endtask

    function automatic bit row_ok(logic [15:0] v);
        int ones;
        bit ok;
        ones = 0;
        ok = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (v[c]) begin
                ones++;
                if (ones > 3) ok = 1'b0;
            end else begin
                ones = 0;
            end
        end
        for (int c = 1; c < 15; c++)
            if (!v[c] && v[c-1] && v[c+1]) ok = 1'b0;
        return ok;
    endfunction

    // Per-tick bookkeeping: 1 capture, 2 replay compare, 3 lane-rule scoreboard
    int                tick_no = 0;
    int                mode = 0;
    bit                check_rates = 1'b0;
    logic [255:0]      cap [50];
    logic [15:0][15:0] prev_p;

    task automatic on_tick();
        logic [15:0][15:0] p;
        logic [15:0]       exp_row;
        bit                moved;
        bit                all_ok;
        p = RedPixelsPattern;
        tick_no++;
        chk("edge_rows_clear", {p[0], p[15]}, 32'd0);
`ifdef SAFE_MEDIAN_EN
        chk("median_row8_clear", p[8], 16'd0);
`endif
        if (mode == 1 && tick_no <= 50) cap[tick_no-1] = p;
        if (mode == 2 && tick_no <= 50) chk("replay_after_reset", p, cap[tick_no-1]);
        if (mode == 3) begin
            all_ok = 1'b1;
            for (int r = 1; r < 15; r++) if (!row_ok(p[r])) all_ok = 1'b0;
            chk("lane_rules", all_ok, 1'b1);
        end
        if (check_rates && tick_no <= 40) begin
            for (int k = 0; k < 3; k++) begin
                int r;
                r = (k == 0) ? 1 : (k == 1) ? 3 : 4;
                moved = (tick_no % (r % 4 + 1)) == 0;
                if (!moved) exp_row = prev_p[r];
                else if (r % 2 == 0) exp_row = {prev_p[r][14:0], p[r][0]};
                else exp_row = {p[r][15], prev_p[r][15:1]};
                chk($sformatf("lane_rate_dir_row%0d_tick%0d", r, tick_no), p[r], exp_row);
            end
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit w, output bit tk);
        reset = rst; enable = en; win = w;
        @(negedge clock);
        tk = tick;
        prev_p = RedPixelsPattern;
        chk("tick_vs_model", tick, m_tick(rst, en));
        @(posedge clock);
        m_edge(rst, en, w);
        #1;
        chk("level_vs_model", level, m_level);
        chk("pattern_vs_model", RedPixelsPattern, model_pat());
        if (tk) on_tick();
    endtask

    task automatic run_ticks(input int n, input string name);
        bit tk;
        int guard;
        tick_no = 0;
        guard = 0;
        while (tick_no < n && guard < 40 * n) begin
            step(1'b0, 1'b1, 1'b0, tk);
            guard++;
        end
        chk({name, "_tick_budget"}, tick_no, n);
    endtask

    typedef struct {
        int win_cycles;
        int exp_level;
        int exp_period;
    } lvl_vec_t;
    lvl_vec_t lv_tab [6];

    initial begin
        bit                tk;
        int                nt;
        int                t1;
        int                t2;
        logic [15:0][15:0] snap;
        logic [1:0]        snap_lv;

        lv_tab[0] = '{0, 0, 4};
        lv_tab[1] = '{5, 1, 2};
        lv_tab[2] = '{1, 2, 1};
        lv_tab[3] = '{3, 3, 1};
        lv_tab[4] = '{2, 3, 1};
        lv_tab[5] = '{5, 3, 1};

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, tk);
        chk("reset_pattern", RedPixelsPattern, 256'd0);
        chk("reset_level", level, 2'd0);
        chk("reset_tick", tk, 1'b0);

        // Tick timing right after release, then capture of the fresh-run sequence
        mode = 1;
        check_rates = 1'b1;
        tick_no = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 1'b0, tk);
            chk($sformatf("tick_cycle%0d", i), tk, (i % 4) == 0);
        end
        nt = 0;
        while (tick_no < 50 && nt < 1000) begin
            step(1'b0, 1'b1, 1'b0, tk);
            nt++;
        end
        chk("capture_tick_budget", tick_no, 50);
        check_rates = 1'b0;
        mode = 0;

        // Freeze with a win pulse inside the window
        snap = RedPixelsPattern;
        snap_lv = level;
        nt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, (i >= 40 && i < 45), tk);
            if (tk) nt++;
        end
        chk("freeze_pattern", RedPixelsPattern, snap);
        chk("freeze_level", level, snap_lv);
        chk("freeze_ticks", nt, 0);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0, tk);

        // One-cycle reset mid-run, then replay must match the fresh run
        step(1'b1, 1'b1, 1'b0, tk);
        chk("midrst_pattern", RedPixelsPattern, 256'd0);
        chk("midrst_level", level, 2'd0);
        mode = 2;
        run_ticks(50, "replay");
        mode = 0;

        // Level / period table
        for (int i = 0; i < 6; i++) begin
            if (lv_tab[i].win_cycles > 0) begin
                for (int k = 0; k < lv_tab[i].win_cycles; k++) step(1'b0, 1'b1, 1'b1, tk);
                chk($sformatf("level_after_win%0d", i), level, lv_tab[i].exp_level);
                for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, tk);
            end
            t1 = -1;
            t2 = -1;
            for (int k = 0; k < 20 && t2 < 0; k++) begin
                step(1'b0, 1'b1, 1'b0, tk);
                if (tk) begin
                    if (t1 < 0) t1 = k;
                    else t2 = k;
                end
            end
            chk($sformatf("level_tab%0d", i), level, lv_tab[i].exp_level);
            chk($sformatf("period_tab%0d", i), (t2 < 0) ? -1 : t2 - t1, lv_tab[i].exp_period);
        end

        // Long run at level 3: lane rules on every tick
        mode = 3;
        run_ticks(5000, "scoreboard");
        mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
